// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave tone bank: per-channel half-period dividers, a global octave shift and a
// first-order sigma-delta mixer. Define POLY_TONE_RELEASE_EN to add a per-channel release hold.
module poly_tone_gen #(
   parameter int NUM_CH = 12,
   parameter int WIDTH = 16,
   parameter logic [NUM_CH*WIDTH-1:0] BASE_HALF = {NUM_CH{WIDTH'(1000)}},
   parameter int RELEASE_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_CH-1:0]               key,
   input  logic [2:0]                      octave,
   output logic [NUM_CH-1:0]               tone,
   output logic [$clog2(NUM_CH+1)-1:0]     active_cnt,
   output logic                            mix_out
);

   localparam int CW = $clog2(NUM_CH + 1);
   localparam int AW = CW + 1;

   logic [NUM_CH-1:0] key_q, key_d;
   logic [2:0]        octave_q, octave_d;
   logic [WIDTH-1:0]  cnt_q [NUM_CH];
   logic [WIDTH-1:0]  cnt_d [NUM_CH];
   logic [WIDTH-1:0]  lim [NUM_CH];
   logic [NUM_CH-1:0] tone_q, tone_d;
   logic [NUM_CH-1:0] en;
   logic [CW-1:0]     active_cnt_q, active_cnt_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [AW-1:0]     mix_sum;
   logic              mix_q, mix_d;

   always_comb begin
      key_d    = key;
      octave_d = octave;
   end

   // A zero base or a shift past the top bit would stall the divider, so clamp the limit to 1.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         lim[i] = BASE_HALF[i*WIDTH +: WIDTH] >> octave_q;
         if (lim[i] == '0) begin
            lim[i] = WIDTH'(1);
         end
      end
   end

`ifdef POLY_TONE_RELEASE_EN
   localparam int TW = (RELEASE_CYCLES > 0) ? $clog2(RELEASE_CYCLES + 1) : 1;

   logic [TW-1:0] rel_q [NUM_CH];
   logic [TW-1:0] rel_d [NUM_CH];

   // The hold loads in the same edge key_q falls, so it covers exactly RELEASE_CYCLES clocks.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         rel_d[i] = rel_q[i];
         en[i]    = key_q[i] | (rel_q[i] != '0);
         if (key_q[i] && !key[i]) begin
            rel_d[i] = TW'(RELEASE_CYCLES);
         end else if (key_q[i]) begin
            rel_d[i] = '0;
         end else if (rel_q[i] != '0) begin
            rel_d[i] = rel_q[i] - TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst) begin
            rel_q[i] <= '0;
         end else begin
            rel_q[i] <= rel_d[i];
         end
      end
   end
`else
   // A negative hold time is meaningless; such a build mutes the bank instead of hiding the error.
   always_comb begin
      en = key_q & {NUM_CH{RELEASE_CYCLES >= 0}};
   end
`endif

   // ">=" lets a count left above a freshly shrunk limit wrap on the next edge instead of running on.
   always_comb begin
      tone_d = tone_q;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!en[i]) begin
            cnt_d[i]  = '0;
            tone_d[i] = 1'b0;
         end else if (cnt_q[i] >= lim[i] - WIDTH'(1)) begin
            cnt_d[i]  = '0;
            tone_d[i] = ~tone_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
         end
      end
   end

   always_comb begin
      active_cnt_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         active_cnt_d = active_cnt_d + CW'(tone_q[i]);
      end
   end

   always_comb begin
      mix_sum = acc_q + AW'(active_cnt_q);
      if (mix_sum >= AW'(NUM_CH)) begin
         mix_d = 1'b1;
         acc_d = mix_sum - AW'(NUM_CH);
      end else begin
         mix_d = 1'b0;
         acc_d = mix_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q        <= '0;
         octave_q     <= '0;
         tone_q       <= '0;
         active_cnt_q <= '0;
         acc_q        <= '0;
         mix_q        <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         key_q        <= key_d;
         octave_q     <= octave_d;
         tone_q       <= tone_d;
         active_cnt_q <= active_cnt_d;
         acc_q        <= acc_d;
         mix_q        <= mix_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign tone       = tone_q;
   assign active_cnt = active_cnt_q;
   assign mix_out    = mix_q;

endmodule

// File: tb/tb_poly_tone_gen.sv
// Testbench for poly_tone_gen: a timing-level reference model checked every cycle, plus directed
// scenarios with hand-computed tone edges. Works with or without POLY_TONE_RELEASE_EN defined.
module tb_poly_tone_gen;

   localparam int NCH = 3;
   localparam int RC  = 30;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] key;
   logic [2:0] octave;
   logic [2:0] tone;
   logic [1:0] active_cnt;
   logic       mix_out;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   poly_tone_gen #(
      .NUM_CH(NCH),
      .WIDTH(8),
      .BASE_HALF({8'd20, 8'd10, 8'd4}),
      .RELEASE_CYCLES(RC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key(key),
      .octave(octave),
      .tone(tone),
      .active_cnt(active_cnt),
      .mix_out(mix_out)
   );

   always #5 clk = ~clk;

   // Reference model: each channel toggles once lim clocks have elapsed since its last toggle or
   // since it was last silent; the mixer is the plain running-remainder division by NCH.
   int         base [NCH] = '{4, 10, 20};
   logic [2:0] mkey;
   int         moct;
   int         mlast [NCH];
   int         mlim_used [NCH];
   int         mrel [NCH];
   logic [2:0] mtone;
   int         mact;
   int         macc;
   logic       mmix;
   int         tcount = 0;

   always @(posedge clk) begin : model
      int lim;
      int s;
      int nact;
      bit en;
      logic [2:0] nt;
      if (rst) begin
         mkey  = '0;
         moct  = 0;
         mtone = '0;
         mact  = 0;
         macc  = 0;
         mmix  = 1'b0;
         for (int i = 0; i < NCH; i++) begin
            mlast[i]     = tcount;
            mlim_used[i] = 1;
            mrel[i]      = 0;
         end
      end else begin
         nt   = mtone;
         nact = int'(mtone[0]) + int'(mtone[1]) + int'(mtone[2]);
         for (int i = 0; i < NCH; i++) begin
            lim = base[i] >> moct;
            if (lim < 1) lim = 1;
            en = mkey[i] || (mrel[i] != 0);
            if (!en) begin
               nt[i]    = 1'b0;
               mlast[i] = tcount;
            end else if (tcount - mlast[i] >= lim) begin
               nt[i]    = ~nt[i];
               mlast[i] = tcount;
            end
            mlim_used[i] = lim;
         end
         s = macc + mact;
         if (s >= NCH) begin
            mmix = 1'b1;
            macc = s - NCH;
         end else begin
            mmix = 1'b0;
            macc = s;
         end
         mact  = nact;
         mtone = nt;
`ifdef POLY_TONE_RELEASE_EN
         for (int i = 0; i < NCH; i++) begin
            if (mkey[i] && !key[i]) mrel[i] = RC;
            else if (mkey[i]) mrel[i] = 0;
            else if (mrel[i] > 0) mrel[i] = mrel[i] - 1;
         end
`endif
         mkey = key;
         moct = int'(octave);
      end
      tcount = tcount + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_assert++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      n_assert++;
      if (actual < lo || actual > hi) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%0d expected %0d..%0d (t=%0t)", name, actual, lo, hi, $time);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] k, input logic [2:0] o);
      key    = k;
      octave = o;
   endtask

   task automatic stepEdge();
      @(posedge clk);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("tone", 32'(tone), 32'(mtone));
         checkOutput("active_cnt", 32'(active_cnt), 32'(mact));
         checkOutput("mix_out", 32'(mix_out), 32'(mmix));
         for (int i = 0; i < NCH; i++) begin
            checkRange($sformatf("cnt%0d_bound", i), int'(dut.cnt_q[i]), 0, mlim_used[i] - 1);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete within 200000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int ones;
      int sum;
      rst = 1'b1;
      applyStimulus(3'b000, 3'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;
      checkOutput("reset_tone", 32'(tone), 32'd0);
      checkOutput("reset_active", 32'(active_cnt), 32'd0);
      checkOutput("reset_mix", 32'(mix_out), 32'd0);

      $display("[TB] idle for 100 cycles");
      repeat (100) stepEdge();
      checkOutput("idle_tone", 32'(tone), 32'd0);
      checkOutput("idle_mix", 32'(mix_out), 32'd0);

      $display("[TB] single channel 0 at octave 0");
      applyStimulus(3'b001, 3'd0);
      repeat (4) stepEdge();
      checkOutput("ch0_before_rise", 32'(tone[0]), 32'd0);
      stepEdge();
      checkOutput("ch0_rise_edge5", 32'(tone[0]), 32'd1);
      repeat (3) stepEdge();
      checkOutput("ch0_high_edge8", 32'(tone[0]), 32'd1);
      stepEdge();
      checkOutput("ch0_fall_edge9", 32'(tone[0]), 32'd0);
      repeat (4) stepEdge();
      checkOutput("ch0_rise_edge13", 32'(tone[0]), 32'd1);
      checkOutput("ch21_silent", 32'(tone[2:1]), 32'd0);
      applyStimulus(3'b000, 3'd0);
      repeat (5) stepEdge();

      $display("[TB] all channels at octave 1, mixer duty");
      applyStimulus(3'b111, 3'd1);
      repeat (12) stepEdge();
      ones = 0;
      sum  = 0;
      for (int c = 0; c < 600; c++) begin
         sum += mact;
         stepEdge();
         if (mix_out === 1'b1) ones++;
      end
      checkOutput("active_sum_600", 32'(sum), 32'd900);
      checkRange("mix_ones_600", ones, 299, 301);
      checkRange("mix_vs_active", ones * 3 - sum, -3, 3);
      applyStimulus(3'b000, 3'd0);
      repeat (3) stepEdge();

      $display("[TB] octave raised mid-note on channel 2");
      applyStimulus(3'b100, 3'd0);
      repeat (16) stepEdge();
      applyStimulus(3'b100, 3'd2);
      stepEdge();
      checkOutput("ch2_old_limit", 32'(tone[2]), 32'd0);
      stepEdge();
      checkOutput("ch2_wrap_toggle", 32'(tone[2]), 32'd1);
      repeat (4) stepEdge();
      checkOutput("ch2_high_4", 32'(tone[2]), 32'd1);
      stepEdge();
      checkOutput("ch2_fall_5", 32'(tone[2]), 32'd0);
      repeat (5) stepEdge();
      checkOutput("ch2_rise_10", 32'(tone[2]), 32'd1);

      $display("[TB] key release and re-press on channel 1");
      applyStimulus(3'b010, 3'd0);
      repeat (10) stepEdge();
      checkOutput("ch1_before_rise", 32'(tone[1]), 32'd0);
      stepEdge();
      checkOutput("ch1_rise_edge11", 32'(tone[1]), 32'd1);
      repeat (4) stepEdge();
      applyStimulus(3'b000, 3'd0);
      stepEdge();
      checkOutput("ch1_drop_edge1", 32'(tone[1]), 32'd1);
      stepEdge();
`ifdef POLY_TONE_RELEASE_EN
      checkOutput("ch1_release_edge2", 32'(tone[1]), 32'd1);
      repeat (18) stepEdge();
      checkOutput("ch1_release_edge20", 32'(tone[1]), 32'd1);
`else
      checkOutput("ch1_silent_edge2", 32'(tone[1]), 32'd0);
      repeat (18) stepEdge();
      checkOutput("ch1_silent_edge20", 32'(tone[1]), 32'd0);
`endif
      repeat (15) stepEdge();
      checkOutput("ch1_silent_edge35", 32'(tone[1]), 32'd0);
      applyStimulus(3'b010, 3'd0);
      repeat (10) stepEdge();
      checkOutput("ch1_repress_before", 32'(tone[1]), 32'd0);
      stepEdge();
      checkOutput("ch1_repress_rise", 32'(tone[1]), 32'd1);

      $display("[TB] reset mid-tone");
      applyStimulus(3'b111, 3'd0);
      repeat (25) stepEdge();
      rst = 1'b1;
      stepEdge();
      checkOutput("rst_tone", 32'(tone), 32'd0);
      checkOutput("rst_active", 32'(active_cnt), 32'd0);
      checkOutput("rst_mix", 32'(mix_out), 32'd0);
      checkOutput("rst_acc", 32'(dut.acc_q), 32'd0);
      rst = 1'b0;
      repeat (4) stepEdge();
      checkOutput("post_rst_ch0_low", 32'(tone[0]), 32'd0);
      stepEdge();
      checkOutput("post_rst_ch0_rise", 32'(tone[0]), 32'd1);
      repeat (5) stepEdge();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/poly_tone_gen.md
Name: poly_tone_gen

Overview:
Parametrised polyphonic square-wave tone bank: NUM_CH independent channels, each with its own half-period divider, gated by per-channel key inputs.
- Global octave shift scales all channels by powers of two.
- Active tones feed a first-order sigma-delta mixer that gives a single 1-bit audio output.
- Sits between the keyboard/pin inputs and the output pads of the piano top level; it replaces the fixed, always-running per-note dividers.

Parameters:
- NUM_CH, 12, number of tone channels (1..16).
- WIDTH, 16, divider counter width in bits.
- BASE_HALF, packed NUM_CH*WIDTH vector, per-channel half-period in clocks at octave 0. Channel i occupies bits [i*WIDTH +: WIDTH]. A field value of 0 is treated as 1.
- RELEASE_CYCLES, 1024, release hold time in clocks. Used only with POLY_TONE_RELEASE_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- key  input  NUM_CH  per-channel gate; 1 = channel sounding
- octave  input  3  right-shift applied to every BASE_HALF field (0..7)
- tone  output  NUM_CH  per-channel square wave
- active_cnt  output  $clog2(NUM_CH+1)  registered popcount of tone
- mix_out  output  1  sigma-delta mixed audio bit

Behaviour:
- Reset: one clock with rst=1 clears all state to 0:
  - key_q, octave_q, per-channel counters, tone, active_cnt, mix accumulator, mix_out.
  - Release timers, when present.
  - rst has priority over every other event.
- Input register: key and octave are registered into key_q and octave_q every clock, giving 1 cycle of latency.
- Limit:
  - lim_i = BASE_HALF_i >> octave_q, clamped to a minimum of 1.
  - Computed combinationally from octave_q each cycle.
- Channel enable: en_i = key_q[i]. With POLY_TONE_RELEASE_EN, en_i also covers the release state (see Optional Feature).
- Channel divider:
  - en_i=0: counter and tone_i are forced to 0 on the next edge. This gives a silent, phase-reset restart.
  - en_i=1, counter >= lim_i-1: counter <= 0 and tone_i toggles. Using >= means a lim_i that shrinks below the current count (octave raised mid-note) wraps on the next edge and never stalls.
  - en_i=1 otherwise: counter increments.
  - Period is 2*lim_i clocks at 50% duty.
  - First tone_i rise occurs lim_i clocks after key_q rises. The key is therefore seen at the pin 1+lim_i edges before tone_i goes high.
- Octave change mid-note: takes effect from the cycle after octave_q updates. No phase reset.
- Counter width: a counter never exceeds lim_i-1, so there is no wrap-around beyond WIDTH.
- active_cnt: registered popcount of the tone vector, 1 cycle after tone.
- Mixer:
  - acc is $clog2(NUM_CH+1)+1 bits.
  - Each clock, s = acc + active_cnt.
  - If s >= NUM_CH: mix_out <= 1 and acc <= s - NUM_CH.
  - Otherwise: mix_out <= 0 and acc <= s.
  - Long-run duty of mix_out is active_cnt/NUM_CH.
  - All channels high gives mix_out constantly 1 (after the first cycle). None high gives constant 0.
- Simultaneous key press/release on different channels: the channels are independent and need no arbitration.
- Reset mid-note: all outputs are 0 on the cycle after the reset edge. Tones restart from phase 0 once key_q is seen again.

Optional Feature:
- Macro: POLY_TONE_RELEASE_EN.
- Defined:
  - Each channel gets a timer of $clog2(RELEASE_CYCLES+1) bits.
  - On a key_q falling edge the timer loads RELEASE_CYCLES. The channel keeps sounding while the timer is nonzero, and the timer decrements each clock.
  - en_i = key_q[i] | (timer_i != 0).
  - Re-press during release: the timer clears to 0. The divider continues without a phase reset.
  - RELEASE_CYCLES=0 behaves as if the macro were undefined.
- Undefined: no timer logic; en_i = key_q[i]. The RELEASE_CYCLES parameter is accepted but ignored.

Test Plan:
Bench configuration: NUM_CH=3, WIDTH=8, BASE_HALF={8'd20,8'd10,8'd4} (ch0=4, ch1=10, ch2=20).
1. Reset then idle: rst high for 2 clocks, key=0 -> tone=0, active_cnt=0, mix_out=0 for 100 cycles.
2. key=3'b001, octave=0 -> tone[0] rises 5 edges after key is applied. Period is 8 clocks at 4 high/4 low. tone[2:1] stay 0.
3. key=3'b111, octave=1 -> periods are 4/10/20 clocks. After the first rise of all channels, the mix_out ones count over 600 cycles equals sum(active_cnt)/3 ±1.
4. ch2 sounding at octave 0 with counter=15, then octave=2 -> lim=5. The next edge wraps the counter and toggles, then the period is 10 clocks. Check the 8-bit counter never exceeds lim-1.
5. Drop key[1] mid-period -> tone[1]=0 two edges later. Re-press -> first rise after 1+10 edges, phase restarted. With POLY_TONE_RELEASE_EN and RELEASE_CYCLES=30: tone[1] keeps toggling for 30 clocks after key_q falls, then goes 0.
6. Assert rst while key=3'b111 mid-tone -> every output is 0 on the next cycle and the mixer accumulator is cleared. After release of rst, tones restart from phase 0.
